// File: rtl/corr_acc_multi.sv
`default_nettype none
// ============================================================================
//  Module   : corr_acc_multi
//  Purpose  : Multi-tap PRN correlator accumulator. Despreads one complex
//             baseband stream against NUM_TAPS local BOC replicas in parallel.
//             It integrates coherently over cfg_coh_num PRN periods, snapshots
//             all taps, then drains them one tap at a time through a shared
//             squarer with a valid/ready handshake.
//  Ports    : rx_clk, rx_rst_n             clock, async active-low reset
//             rx_data_real/imag [DAT_WIDTH] I/Q samples, two's complement
//             rx_loc_boc [NUM_TAPS]         replica chip per tap (1=+1, 0=-1)
//             rx_prn_sop / rx_prn_eop       first / last sample of a period
//             cfg_coh_num [COH_WIDTH]       periods per block (0 acts as 1)
//             tx_valid / tx_ready           output handshake
//             tx_tap [3]                    tap index of the current word
//             tx_corr_real/imag [OUT_WIDTH] truncated correlation
//             tx_power [2*OUT_WIDTH]        real^2 + imag^2, unsigned
//             tx_overflow                   sticky: a dump was discarded
//  Revision : 1.0 - initial release
// ============================================================================
module corr_acc_multi #(
  parameter int DAT_WIDTH = 16,
  parameter int NUM_TAPS  = 3,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 24,
  parameter int COH_WIDTH = 8
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst_n,
  input  logic [DAT_WIDTH-1:0]        rx_data_real,
  input  logic [DAT_WIDTH-1:0]        rx_data_imag,
  input  logic [NUM_TAPS-1:0]         rx_loc_boc,
  input  logic                        rx_prn_sop,
  input  logic                        rx_prn_eop,
  input  logic [COH_WIDTH-1:0]        cfg_coh_num,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [2:0]                  tx_tap,
  output logic signed [OUT_WIDTH-1:0] tx_corr_real,
  output logic signed [OUT_WIDTH-1:0] tx_corr_imag,
  output logic [2*OUT_WIDTH-1:0]      tx_power,
  output logic                        tx_overflow
);

  localparam int       EXT_WIDTH = ACC_WIDTH - DAT_WIDTH;
  localparam logic [2:0] LAST_TAP = 3'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;

  logic signed [ACC_WIDTH-1:0] acc_re     [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] acc_im     [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] acc_re_nxt [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] acc_im_nxt [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] hold_re    [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] hold_im    [NUM_TAPS];

  logic [COH_WIDTH-1:0] coh_cnt;
  logic [COH_WIDTH-1:0] coh_num_q;
  logic                 first_q;

  logic signed [ACC_WIDTH-1:0] x_re;
  logic signed [ACC_WIDTH-1:0] x_im;
  logic                        load;
  logic [COH_WIDTH-1:0]        cfg_eff;
  logic [COH_WIDTH-1:0]        coh_lim;
  logic                        dump;

  assign x_re = {{EXT_WIDTH{rx_data_real[DAT_WIDTH-1]}}, rx_data_real};
  assign x_im = {{EXT_WIDTH{rx_data_imag[DAT_WIDTH-1]}}, rx_data_imag};

  // Only the first sop of a block reloads; later sops keep integrating.
  assign load    = rx_prn_sop & first_q;
  assign cfg_eff = (cfg_coh_num == '0) ? COH_WIDTH'(1) : cfg_coh_num;
  // On the loading cycle the freshly latched length already applies, so a
  // one-sample block (sop and eop together) with length 1 dumps immediately.
  assign coh_lim = load ? cfg_eff : coh_num_q;
  assign dump    = rx_prn_eop & (coh_cnt == coh_lim - COH_WIDTH'(1));

  // Per-tap despreading: the replica chip selects +x or -x.
  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
    logic signed [ACC_WIDTH-1:0] c_re;
    logic signed [ACC_WIDTH-1:0] c_im;
    assign c_re          = rx_loc_boc[t] ? x_re : -x_re;
    assign c_im          = rx_loc_boc[t] ? x_im : -x_im;
    assign acc_re_nxt[t] = load ? c_re : acc_re[t] + c_re;
    assign acc_im_nxt[t] = load ? c_im : acc_im[t] + c_im;
  end

  // Select the tap being drained and keep only its MSBs (floor truncation).
  logic signed [OUT_WIDTH-1:0] trunc_re;
  logic signed [OUT_WIDTH-1:0] trunc_im;

  always_comb begin
    trunc_re = '0;
    trunc_im = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      if (tx_tap == 3'(t)) begin
        trunc_re = hold_re[t][ACC_WIDTH-1 -: OUT_WIDTH];
        trunc_im = hold_im[t][ACC_WIDTH-1 -: OUT_WIDTH];
      end
    end
  end

  // The dropped LSBs of the snapshot are intentionally never observed.
  if (OUT_WIDTH < ACC_WIDTH) begin : g_lsb_sink
    logic unused_hold_lsb;
    always_comb begin
      unused_hold_lsb = 1'b0;
      for (int t = 0; t < NUM_TAPS; t++) begin
        unused_hold_lsb = unused_hold_lsb ^ (^hold_re[t][ACC_WIDTH-OUT_WIDTH-1:0])
                                          ^ (^hold_im[t][ACC_WIDTH-OUT_WIDTH-1:0]);
      end
    end
  end

  // Shared squarer. Each square fits signed 2*OUT_WIDTH; the sum can reach
  // 2^(2*OUT_WIDTH-1), so it is added as unsigned.
  logic signed [2*OUT_WIDTH-1:0] ext_re;
  logic signed [2*OUT_WIDTH-1:0] ext_im;
  logic signed [2*OUT_WIDTH-1:0] sq_re;
  logic signed [2*OUT_WIDTH-1:0] sq_im;
  logic [2*OUT_WIDTH-1:0]        power;

  assign ext_re = {{OUT_WIDTH{trunc_re[OUT_WIDTH-1]}}, trunc_re};
  assign ext_im = {{OUT_WIDTH{trunc_im[OUT_WIDTH-1]}}, trunc_im};
  assign sq_re  = ext_re * ext_re;
  assign sq_im  = ext_im * ext_im;
  assign power  = $unsigned(sq_re) + $unsigned(sq_im);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      for (int t = 0; t < NUM_TAPS; t++) begin
        acc_re[t]  <= '0;
        acc_im[t]  <= '0;
        hold_re[t] <= '0;
        hold_im[t] <= '0;
      end
      coh_cnt      <= '0;
      coh_num_q    <= COH_WIDTH'(1);
      first_q      <= 1'b1;
      state        <= S_IDLE;
      tx_valid     <= 1'b0;
      tx_tap       <= 3'd0;
      tx_corr_real <= '0;
      tx_corr_imag <= '0;
      tx_power     <= '0;
      tx_overflow  <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_TAPS; t++) begin
        acc_re[t] <= acc_re_nxt[t];
        acc_im[t] <= acc_im_nxt[t];
      end

      if (dump)      first_q <= 1'b1;
      else if (load) first_q <= 1'b0;

      if (load) coh_num_q <= cfg_eff;

      if (rx_prn_eop) coh_cnt <= dump ? '0 : coh_cnt + COH_WIDTH'(1);

      // A dump only lands when the drain is idle; otherwise it is lost and
      // the snapshot being drained stays intact.
      if (dump && state == S_IDLE) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          hold_re[t] <= acc_re_nxt[t];
          hold_im[t] <= acc_im_nxt[t];
        end
      end
      if (dump && state != S_IDLE) tx_overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (dump) begin
            tx_tap <= 3'd0;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          tx_corr_real <= trunc_re;
          tx_corr_imag <= trunc_im;
          tx_power     <= power;
          tx_valid     <= 1'b1;
          state        <= S_OUT;
        end
        S_OUT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_tap == LAST_TAP) begin
              state <= S_IDLE;
            end else begin
              tx_tap <= tx_tap + 3'd1;
              state  <= S_MUL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/corr_acc_multi.md
Name: corr_acc_multi

Overview:
- Multi-tap, multi-period successor of the single-tap PRN correlator accumulator.
- Despreads one complex baseband stream against NUM_TAPS local BOC replicas (e.g. early/prompt/late) in parallel.
- Integrates coherently over a run-time number of PRN periods, then snapshots all taps.
- Drains the snapshots one tap at a time through one shared squarer, using a valid/ready handshake towards the tracking loop.

Parameters:
- DAT_WIDTH, 16: input I/Q sample width, two's complement.
- NUM_TAPS, 3: number of parallel correlator taps, 1..8.
- ACC_WIDTH, 40: accumulator width, two's complement, wrap-around.
- OUT_WIDTH, 24: truncated correlation width presented at the output; must be <= ACC_WIDTH.
- COH_WIDTH, 8: width of the coherent-period count.

Ports:
- rx_clk, in, 1: clock.
- rx_rst_n, in, 1: asynchronous, active-low reset.
- rx_data_real, in, DAT_WIDTH: I sample.
- rx_data_imag, in, DAT_WIDTH: Q sample.
- rx_loc_boc, in, NUM_TAPS: local replica chip per tap; 1 = +1, 0 = -1. Aligned with the data on the same cycle.
- rx_prn_sop, in, 1: first sample of a PRN period.
- rx_prn_eop, in, 1: last sample of a PRN period.
- cfg_coh_num, in, COH_WIDTH: PRN periods per coherent block; 0 is treated as 1.
- tx_valid, out, 1: output word valid.
- tx_ready, in, 1: downstream accepts the word.
- tx_tap, out, 3: tap index of the current word.
- tx_corr_real, out, OUT_WIDTH: truncated I correlation.
- tx_corr_imag, out, OUT_WIDTH: truncated Q correlation.
- tx_power, out, 2*OUT_WIDTH: unsigned, real^2 + imag^2.
- tx_overflow, out, 1: sticky flag, a dump was lost.

Behaviour:
- Reset: rx_rst_n low asynchronously clears all of the following, at any time, including mid-block or mid-drain:
  - accumulators, hold registers, coh_cnt
  - coh_num_q = 1, first_q = 1
  - FSM = IDLE, tx_valid = 0, tx_tap = 0, tx_corr_real/imag = 0, tx_power = 0, tx_overflow = 0
- Contribution per tap k: c = rx_loc_boc[k] ? +x : -x, with x sign-extended to ACC_WIDTH. Applied to I and Q independently.
- Accumulate every cycle:
  - if rx_prn_sop and first_q: acc = c (load)
  - otherwise: acc = acc + c
  - A rx_prn_sop that is not the first in the block does not clear the accumulator.
- first_q: set to 1 on dump; cleared on the cycle of the loading sop.
- cfg_coh_num is latched into coh_num_q on the loading sop. A mid-block change of cfg_coh_num has no effect until the next block.
- On rx_prn_eop:
  - if coh_cnt == coh_num_q-1: dump and coh_cnt = 0
  - else: coh_cnt = coh_cnt + 1
- Dump:
  - Hold registers capture acc_next, i.e. the accumulated value including the eop-cycle sample, for all taps and I/Q simultaneously.
  - sop and eop in the same cycle: that sample is both loaded and dumped.
- Truncation: out = hold[ACC_WIDTH-1 -: OUT_WIDTH]. LSBs are dropped (floor), with no rounding and no saturation.
- Drain FSM, with tap counter k:
  - IDLE: on dump, k = 0, go to MUL.
  - MUL (1 cycle): register truncated re/im of tap k and re^2 + im^2. Go to OUT.
  - OUT: tx_valid = 1, outputs stable. On tx_valid & tx_ready: if k == NUM_TAPS-1 go to IDLE, else k = k+1 and go to MUL. tx_valid drops in MUL cycles.
- Latency: eop on cycle T gives the first tx_valid on cycle T+2. With tx_ready held at 1, taps appear on T+2, T+4, ..., one word every 2 cycles.
- Overflow: a dump while the FSM is not IDLE is discarded. Hold registers and the in-progress drain are untouched, and tx_overflow is set and stays set until reset. Accumulation and the period count continue normally.
- Wrap-around: the accumulators wrap modulo 2^ACC_WIDTH with no flag. The tx_power width is sufficient for (-2^(OUT_WIDTH-1))^2 * 2 with no overflow.

Test Plan:
1. Single period, NUM_TAPS=3, DAT_WIDTH=16, ACC_WIDTH=40, OUT_WIDTH=24, cfg_coh_num=1; 1000 samples of I=+100, Q=-50; loc_boc taps = all 1 / all 0 / alternating (starting 1).
   Required: hold I = +100000 / -100000 / 0, Q = -50000 / +50000 / 0.
   Required: tx_corr_real for tap0 = 100000>>16 = 1, tap1 = -2 (floor), tap2 = 0.
   Required: tx_power for tap0 = 1 + 1 = 2.
2. Coherent integration, cfg_coh_num=4; four periods of 10 samples, I=+1000, loc_boc=1.
   Required: exactly one dump after the 4th eop, hold I = 40000.
   Required: intermediate sops do not clear the accumulator.
   Required: first tx_valid exactly 2 cycles after the 4th eop.
3. Backpressure: tx_ready = 0 for 20 cycles after the first tx_valid.
   Required: tx_valid stays high with tx_tap = 0 and stable data.
   Required: after tx_ready rises, taps 1 and 2 follow, each preceded by one MUL cycle.
4. Overflow: cfg_coh_num=1 with 2-sample periods and tx_ready = 0.
   Required: the second dump sets tx_overflow.
   Required: the original tap 0 data is unchanged; the drain completes with the first block's values.
   Required: tx_overflow remains 1 afterwards.
5. Boundary cases: sop and eop in the same cycle with I = -32768, loc_boc = 0.
   Required: hold I = +32768.
   Required: cfg_coh_num = 0 behaves as 1.
   Required: changing cfg_coh_num from 4 to 2 mid-block still dumps after 4 periods.
6. Reset mid-drain: assert rx_rst_n = 0 while tx_valid = 1 (asynchronously, between clock edges).
   Required: tx_valid, tx_power and tx_overflow go to 0 immediately.
   Required: the next block after release restarts with coh_cnt = 0 and a loading sop.
